csa_resolve: RTL and testbench
==============================

Name: csa_resolve

Overview:
- Sequential carry-propagate resolver: converts a carry-save pair (S, C) from the CSA array back to ordinary binary, SUM = (S + C) mod 2^N, with the final carry-out reported separately.
- Sits at the output of the Barrett multiplier datapath, after the last CSA stage, before the comparison/subtraction correction step.
- Adds W bits per cycle with a registered ripple carry, trading latency for area.
- Uses a valid/ready handshake on both input and output.

Parameters:
- N, 64, operand width; must be a positive multiple of W.
- W, 16, chunk width added per cycle; 1 <= W <= N.
- K (localparam), N/W, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  S and C are valid
- in_ready  output  1  block can accept an operand pair
- S  input  N  carry-save sum vector
- C  input  N  carry-save carry vector, already aligned/shifted by the CSA
- out_valid  output  1  SUM and COUT are valid
- out_ready  input  1  consumer accepts the result
- SUM  output  N  (S + C) mod 2^N
- COUT  output  1  bit N of S + C

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, SUM=0, COUT=0.
  - Internal S/C shift registers, carry and chunk counter all go to 0.
  - Reset mid-RUN or in DONE discards the operation silently.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch S and C, clear the carry register, set the chunk index k=0, go to RUN.
  - in_ready is combinational from state only; it never depends on in_valid.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each edge computes {c, r} = S[kW+W-1:kW] + C[kW+W-1:kW] + carry.
  - Writes r into SUM[kW+W-1:kW], carry <= c, k <= k+1.
  - A shift-register implementation is acceptable if SUM bit placement is identical.
  - On the edge processing k=K-1: COUT <= c, go to DONE.
  - in_valid is ignored here; the upstream stage must hold its data.
- State DONE:
  - out_valid=1; SUM and COUT are stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: go to IDLE, deassert out_valid.
  - SUM and COUT keep their last value; they are not cleared.
- Latency:
  - Input handshake at edge t puts the block in RUN for edges t+1..t+K.
  - out_valid is high from edge t+K; first result visible in the cycle after edge t+K.
  - Throughput: one result per K+2 cycles when out_ready is held high.
- Arithmetic:
  - Unsigned.
  - SUM wraps modulo 2^N; COUT=1 exactly when S+C >= 2^N.
  - No carry enters chunk 0.
- W=N degenerate case: K=1, one RUN cycle, same handshake.
- out_ready while not in DONE: ignored.
- Simultaneous in_valid and out_ready in DONE: the input is not accepted that cycle (in_ready=0); it is accepted in the following IDLE cycle.

Test Plan (N=16, W=4 unless stated):
- Reset: rst_n low 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, SUM=0, COUT=0; state stays IDLE.
- Basic add: S=0x1234, C=0x0F0F, out_ready=1 -> out_valid high 4 edges after acceptance, SUM=0x2143, COUT=0; back in IDLE one edge later.
- Full carry ripple: S=0xFFFF, C=0x0001 -> SUM=0x0000, COUT=1 (carry crosses all 4 chunks); S=0x8000, C=0x8000 -> SUM=0x0000, COUT=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> SUM and COUT stable, in_ready=0 throughout; release -> one accepted result, no duplicate.
- Reset mid-operation: accept S=0xAAAA, C=0x5555, pulse rst_n low on the second RUN edge -> out_valid never asserts for it; a new pair S=0x0001, C=0x0002 gives SUM=0x0003.
- Back-to-back and parameter sweep: 1000 random pairs for (N,W) in {(16,4),(64,16),(8,8),(12,1)} with random valid/ready gaps -> each SUM/COUT matches the reference S+C; result count equals input count.

Source files
------------

// File: rtl/csa_resolve.sv
// Sequential carry-propagate resolver: turns a carry-save pair (S, C) into
// SUM = (S + C) mod 2^N plus carry-out, adding W bits per clock.
module csa_resolve #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] S,
    input  logic [N-1:0] C,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] SUM,
    output logic         COUT
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid outputs depend on state only, never on the partner.

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    s_q, s_d;
    logic [N-1:0]    c_q, c_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [CW-1:0]   k_q, k_d;
    logic [W:0]      chunk;
    logic [N-1:0]    sum_shift;

    // Operands shift right so the active chunk is always in the low W bits.
    assign chunk = {1'b0, s_q[W-1:0]} + {1'b0, c_q[W-1:0]} + {{W{1'b0}}, carry_q};

    // Result chunks enter at the top; after K shifts chunk 0 sits at bit 0.
    generate
        if (W == N) begin : g_single
            assign sum_shift = chunk[W-1:0];
        end else begin : g_multi
            assign sum_shift = {chunk[W-1:0], sum_q[N-1:W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = S;
                    c_d     = C;
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = s_q >> W;
                c_d     = c_q >> W;
                sum_d   = sum_shift;
                carry_d = chunk[W];
                k_d     = k_q + CW'(1);
                if (k_q == CW'(K - 1)) begin
                    cout_d  = chunk[W];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign SUM       = sum_q;
    assign COUT      = cout_q;

endmodule

// File: tb/tb_csa_resolve.sv
// Bench for csa_resolve: directed N=16/W=4 scenarios plus randomized traffic
// on four (N, W) shapes, checked against plain S + C arithmetic.
module tb_csa_resolve;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- directed instance (N=16, W=4) ----------------
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S;
    logic [15:0] C;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] SUM;
    logic        COUT;

    csa_resolve #(.N(16), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .COUT      (COUT)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'd4);
    endtask

    task automatic run_op(input logic [15:0] s, input logic [15:0] c, input int hold, input string tag);
        logic [16:0] full;
        full = {1'b0, s} + {1'b0, c};
        chk({tag, "_in_ready_idle"}, 128'(in_ready), 128'd1);
        S = s;
        C = c;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        chk({tag, "_in_ready_run"}, 128'(in_ready), 128'd0);
        wait_done(tag);
        chk({tag, "_sum"}, 128'(SUM), 128'(full[15:0]));
        chk({tag, "_cout"}, 128'(COUT), 128'(full[16]));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
            chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
            chk({tag, "_hold_sum"}, 128'({COUT, SUM}), 128'(full));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_after"}, 128'(out_valid), 128'd0);
        chk({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
        chk({tag, "_sum_kept"}, 128'({COUT, SUM}), 128'(full));
        tick();
        chk({tag, "_no_dup"}, 128'(out_valid), 128'd0);
    endtask

    // ---------------- randomized instances ----------------
    localparam int NUM_RAND = 1000;
    localparam int BUDGET   = 60000;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : cfg
            localparam int NN = (g == 0) ? 16 : (g == 1) ? 64 : (g == 2) ? 8 : 12;
            localparam int WW = (g == 0) ? 4  : (g == 1) ? 16 : (g == 2) ? 8 : 1;

            logic          r_rst_n;
            logic          r_in_valid;
            logic          r_in_ready;
            logic [NN-1:0] r_s;
            logic [NN-1:0] r_c;
            logic          r_out_valid;
            logic          r_out_ready;
            logic [NN-1:0] r_sum;
            logic          r_cout;
            logic [NN:0]   exp_q[$];
            logic          done = 1'b0;
            int            sent = 0;
            int            got  = 0;

            csa_resolve #(.N(NN), .W(WW)) u_dut (
                .clk       (clk),
                .rst_n     (r_rst_n),
                .in_valid  (r_in_valid),
                .in_ready  (r_in_ready),
                .S         (r_s),
                .C         (r_c),
                .out_valid (r_out_valid),
                .out_ready (r_out_ready),
                .SUM       (r_sum),
                .COUT      (r_cout)
            );

            initial begin : driver
                logic [63:0] ra;
                logic [63:0] rb;
                logic        rdy;
                int          w;
                r_rst_n    = 1'b0;
                r_in_valid = 1'b0;
                r_s        = '0;
                r_c        = '0;
                repeat (2) begin @(posedge clk); #1; end
                r_rst_n = 1'b1;
                for (int i = 0; i < NUM_RAND; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    case ($urandom_range(0, 5))
                        0: ra = '1;
                        1: begin ra = '1; rb = 64'd1; end
                        default: ;
                    endcase
                    r_s        = ra[NN-1:0];
                    r_c        = rb[NN-1:0];
                    r_in_valid = 1'b1;
                    w = 0;
                    rdy = 1'b0;
                    while (!rdy && w < 200) begin
                        rdy = r_in_ready;
                        @(posedge clk);
                        #1;
                        w++;
                    end
                    if (!rdy) begin
                        chk($sformatf("cfg%0d_in_timeout", g), 128'd0, 128'd1);
                        break;
                    end
                    exp_q.push_back({1'b0, ra[NN-1:0]} + {1'b0, rb[NN-1:0]});
                    sent++;
                    r_in_valid = 1'b0;
                end
                r_in_valid = 1'b0;
            end

            initial begin : monitor
                logic [NN:0] e;
                int          cyc;
                r_out_ready = 1'b0;
                cyc = 0;
                @(posedge clk);
                #1;
                while (got < NUM_RAND && cyc < BUDGET) begin
                    r_out_ready = ($urandom_range(0, 1) == 1);
                    if (r_out_valid && r_out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("cfg%0d_unexpected_out", g), 128'd1, 128'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("cfg%0d_sum", g), 128'(r_sum), 128'(e[NN-1:0]));
                            chk($sformatf("cfg%0d_cout", g), 128'(r_cout), 128'(e[NN]));
                        end
                        got++;
                    end
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                r_out_ready = 1'b0;
                chk($sformatf("cfg%0d_result_count", g), 128'(got), 128'(NUM_RAND));
                chk($sformatf("cfg%0d_input_count", g), 128'(sent), 128'(NUM_RAND));
                done = 1'b1;
            end
        end
    endgenerate

    // ---------------- directed sequence and report ----------------
    initial begin : main
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        S         = 16'h1234;
        C         = 16'h4321;
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_sum", 128'(SUM), 128'd0);
        chk("rst_cout", 128'(COUT), 128'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("rst_stays_idle", 128'(in_ready), 128'd1);

        run_op(16'h1234, 16'h0F0F, 0, "basic");
        chk("basic_literal", 128'(SUM), 128'h2143);
        run_op(16'hFFFF, 16'h0001, 0, "ripple");
        chk("ripple_literal", 128'({COUT, SUM}), 128'h10000);
        run_op(16'h8000, 16'h8000, 0, "msb");
        run_op(16'hBEEF, 16'h1357, 5, "backpressure");

        // Reset asserted at the second RUN edge must discard the operation.
        S = 16'hAAAA;
        C = 16'h5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("midrst_out_valid", 128'(out_valid), 128'd0);
            chk("midrst_in_ready", 128'(in_ready), 128'd1);
            tick();
        end
        run_op(16'h0001, 16'h0002, 0, "after_rst");
        chk("after_rst_literal", 128'(SUM), 128'h0003);

        // In DONE, in_valid together with out_ready is not taken that cycle.
        S = 16'h0100;
        C = 16'h0200;
        in_valid = 1'b1;
        tick();
        S = 16'h0003;
        C = 16'h0004;
        wait_done("overlap_first");
        chk("overlap_first_sum", 128'(SUM), 128'h0300);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("overlap_not_taken", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("overlap_taken_next", 128'(in_ready), 128'd0);
        wait_done("overlap_second");
        chk("overlap_second_sum", 128'(SUM), 128'h0007);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        w = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) && w < BUDGET + 100) begin
            tick();
            w++;
        end
        if (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done)) begin
            chk("random_timeout", 128'd0, 128'd1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
